// File: rtl/debounce_pkg.sv
// Shared state encoding and default parameter values for the button debounce bank.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HELD      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } db_state_e;

    localparam int N_DEF               = 4;
    localparam int DEBOUNCE_CYCLES_DEF = 2_000_000;
    localparam int LONG_CYCLES_DEF     = 100_000_000;
    localparam int LONG_EN_DEF         = 1;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM, optional long-press counter.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
    parameter int LONG_EN         = LONG_EN_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic button_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_press_o
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             meta_q;
    logic             sync_q;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_clr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= button_i;
            sync_q <= meta_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_clr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sync_q) begin
                    state_d = ST_WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            ST_WAIT_HIGH: begin
                if (!sync_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HELD;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (!sync_q) begin
                    state_d = ST_WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            ST_WAIT_LOW: begin
                // A return to high inside the window is a glitch: resume HELD silently.
                if (sync_q) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                    cnt_d     = '0;
                    long_clr  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

    if (LONG_EN != 0) begin : g_long
        localparam int            LONG_W   = $clog2(LONG_CYCLES + 1);
        localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES);
        localparam logic [LONG_W-1:0] LONG_ONE = LONG_W'(1);

        logic [LONG_W-1:0] long_q, long_d;
        logic              long_press_q, long_press_d;

        // Saturates at LONG_MAX so the pulse fires once per press.
        always_comb begin
            long_d       = long_q;
            long_press_d = 1'b0;
            if (long_clr) begin
                long_d = '0;
            end else if (state_q == ST_HELD && long_q != LONG_MAX) begin
                long_d       = long_q + LONG_ONE;
                long_press_d = (long_q == LONG_MAX - LONG_ONE);
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                long_q       <= '0;
                long_press_q <= 1'b0;
            end else begin
                long_q       <= long_d;
                long_press_q <= long_press_d;
            end
        end

        assign long_press_o = long_press_q;
    end else begin : g_nolong
        assign long_press_o = 1'b0;
    end

endmodule

// File: rtl/debounce_bank.sv
// Bank of N independent debounced button channels with press/release/long-press pulses.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int N               = N_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
    parameter int LONG_EN         = LONG_EN_DEF
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [N-1:0] Button,
    output logic [N-1:0] Level,
    output logic [N-1:0] Press,
    output logic [N-1:0] Release,
    output logic [N-1:0] LongPress
);

    for (genvar i = 0; i < N; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES),
            .LONG_EN        (LONG_EN)
        ) u_ch (
            .clk_i       (Clk),
            .rst_i       (Reset),
            .button_i    (Button[i]),
            .level_o     (Level[i]),
            .press_o     (Press[i]),
            .release_o   (Release[i]),
            .long_press_o(LongPress[i])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank with N=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
module tb_debounce_bank;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] Button = 4'b0000;
    logic [3:0] Level, Press, Release, LongPress;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] btn;
        logic [3:0] lvl;
        logic [3:0] pr;
        logic [3:0] rl;
        logic [3:0] lp;
    } vec_t;

    typedef struct {
        logic [15:0] exp;
        string       name;
    } sb_t;

    sb_t  sb_q[$];
    vec_t tbl[18];

    debounce_bank #(
        .N(4), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .LONG_EN(1)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Button(Button),
        .Level(Level), .Press(Press), .Release(Release), .LongPress(LongPress)
    );

    always #5 Clk = ~Clk;

    // Each entry is the expected {Level,Press,Release,LongPress} after the next rising edge.
    always @(posedge Clk) begin
        #1;
        if (sb_q.size() != 0) begin
            sb_t e;
            e = sb_q.pop_front();
            checks++;
            if ({Level, Press, Release, LongPress} !== e.exp) begin
                failures++;
                $display("FAIL %s: got L=%b P=%b R=%b LP=%b, want L=%b P=%b R=%b LP=%b",
                         e.name, Level, Press, Release, LongPress,
                         e.exp[15:12], e.exp[11:8], e.exp[7:4], e.exp[3:0]);
            end
        end
    end

    task automatic step(input logic rst, input logic [3:0] btn, input logic [3:0] lvl,
                        input logic [3:0] pr, input logic [3:0] rl, input logic [3:0] lp,
                        input string nm);
        sb_t e;
        @(negedge Clk);
        Reset = rst;
        Button = btn;
        e.exp = {lvl, pr, rl, lp};
        e.name = nm;
        sb_q.push_back(e);
    endtask

    initial begin
        logic [3:0] b, l, p, r, lp;

        // ch0 clean press/release, ch1 bounce 1,0,1,1,0 then stable 1
        tbl[0]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[2]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[3]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[4]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[5]  = '{4'b0011, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        tbl[6]  = '{4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        tbl[7]  = '{4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        tbl[8]  = '{4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        tbl[9]  = '{4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        tbl[10] = '{4'b0010, 4'b0011, 4'b0010, 4'b0000, 4'b0000};
        tbl[11] = '{4'b0010, 4'b0011, 4'b0000, 4'b0000, 4'b0000};
        tbl[12] = '{4'b0010, 4'b0011, 4'b0000, 4'b0000, 4'b0000};
        tbl[13] = '{4'b0010, 4'b0011, 4'b0000, 4'b0000, 4'b0000};
        tbl[14] = '{4'b0010, 4'b0011, 4'b0000, 4'b0000, 4'b0000};
        tbl[15] = '{4'b0010, 4'b0010, 4'b0000, 4'b0001, 4'b0000};
        tbl[16] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
        tbl[17] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};

        step(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "reset0");
        step(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "reset1");

        for (int i = 0; i < 18; i++)
            step(1'b0, tbl[i].btn, tbl[i].lvl, tbl[i].pr, tbl[i].rl, tbl[i].lp,
                 $sformatf("table[%0d]", i));

        // Reset while ch0/ch1 are HELD with buttons still high
        for (int k = 0; k < 22; k++) begin
            b = (k < 15) ? 4'b0011 : 4'b0000;
            l = 4'b0000; p = 4'b0000; r = 4'b0000; lp = 4'b0000;
            if (k <= 4) l = 4'b0010;
            if (k == 5 || k == 6) l = 4'b0011;
            if (k == 5) p = 4'b0001;
            if (k >= 13 && k <= 19) l = 4'b0011;
            if (k == 13) p = 4'b0011;
            if (k == 20) r = 4'b0011;
            step(k == 7, b, l, p, r, lp, $sformatf("rst_seq[%0d]", k));
        end

        // All four pressed together; ch3 glitches low; ch2/ch3 reach long press
        for (int m = 0; m < 43; m++) begin
            b[0] = (m < 8);
            b[1] = (m < 8);
            b[2] = (m < 35);
            b[3] = (m < 35) && !(m == 10 || m == 11);
            l[1:0] = (m >= 5 && m <= 12) ? 2'b11 : 2'b00;
            l[3:2] = (m >= 5 && m <= 39) ? 2'b11 : 2'b00;
            p  = (m == 5) ? 4'b1111 : 4'b0000;
            r  = (m == 13) ? 4'b0011 : (m == 40) ? 4'b1100 : 4'b0000;
            lp = (m == 25) ? 4'b0100 : (m == 27) ? 4'b1000 : 4'b0000;
            step(1'b0, b, l, p, r, lp, $sformatf("long_seq[%0d]", m));
        end

        repeat (3) @(posedge Clk);
        #2;
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending entries, want 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
